// File: rtl/ifid_pkg.sv
// Shared types and constants for the fetch-to-decode packet queue.
package ifid_pkg;

  typedef struct packed {
    logic [31:0] instr1;
    logic [31:0] instr2;
    logic [31:0] pca;
    logic [31:0] cia;
  } ifid_entry_t;

  localparam int          IFID_DEPTH = 4;
  localparam logic [31:0] NOP_INSTR  = 32'h0000_0000;

endpackage

// File: rtl/ifid_queue_mem.sv
// Packet storage for ifid_queue: synchronous write port, asynchronous read port.
module ifid_queue_mem
  import ifid_pkg::*;
#(
  parameter int DEPTH = IFID_DEPTH,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          CLK,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  ifid_entry_t   i_wdata,
  input  logic [AW-1:0] i_raddr,
  output ifid_entry_t   o_rdata
);

  ifid_entry_t r_mem [DEPTH];

  // NOTE: storage has no reset; the empty flag masks stale entries, and
  // leaving the array unreset lets it map onto plain RAM/register files.
  always_ff @(posedge CLK) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/ifid_queue.sv
// Fetch/decode decoupling FIFO: first-word-fall-through head, flush on redirect,
// sticky overflow/underflow flags.
module ifid_queue
  import ifid_pkg::*;
#(
  parameter  int DEPTH = IFID_DEPTH,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic          CLK,
  input  logic          RESET,
  input  logic          flush,
  input  logic          push_req,
  input  logic [31:0]   instr1_in,
  input  logic [31:0]   instr2_in,
  input  logic [31:0]   pca_in,
  input  logic [31:0]   cia_in,
  output logic          full,
  output logic          almost_full,
  input  logic          pop_req,
  output logic          empty,
  output logic [31:0]   instr1_out,
  output logic [31:0]   instr2_out,
  output logic [31:0]   pca_out,
  output logic [31:0]   cia_out,
  output logic [AW:0]   count,
  output logic          overflow_err,
  output logic          underflow_err
);

  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [AW:0] AF_CNT   = (AW+1)'(DEPTH - 1);

  logic [AW-1:0] r_rd_ptr;
  logic [AW-1:0] r_wr_ptr;
  logic [AW:0]   r_count;
  logic          r_overflow;
  logic          r_underflow;

  logic          w_push_ok;
  logic          w_pop_ok;
  ifid_entry_t   w_wdata;
  ifid_entry_t   w_head;

  assign full        = (r_count == FULL_CNT);
  assign almost_full = (r_count >= AF_CNT);
  assign empty       = (r_count == '0);
  assign count       = r_count;

  // Acceptance uses pre-edge status, so a pop never makes room for a same-cycle push.
  assign w_push_ok = push_req && !full  && !flush;
  assign w_pop_ok  = pop_req  && !empty && !flush;

  assign w_wdata = '{instr1: instr1_in, instr2: instr2_in, pca: pca_in, cia: cia_in};

  ifid_queue_mem #(.DEPTH(DEPTH), .AW(AW)) u_mem (
    .CLK     (CLK),
    .i_we    (w_push_ok),
    .i_waddr (r_wr_ptr),
    .i_wdata (w_wdata),
    .i_raddr (r_rd_ptr),
    .o_rdata (w_head)
  );

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_rd_ptr    <= '0;
      r_wr_ptr    <= '0;
      r_count     <= '0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else if (flush) begin
      r_rd_ptr    <= '0;
      r_wr_ptr    <= '0;
      r_count     <= '0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + 1'b1;
      r_count <= r_count + {{AW{1'b0}}, w_push_ok} - {{AW{1'b0}}, w_pop_ok};
      if (push_req && full)  r_overflow  <= 1'b1;
      if (pop_req  && empty) r_underflow <= 1'b1;
    end
  end

  assign overflow_err  = r_overflow;
  assign underflow_err = r_underflow;

  // An empty queue presents an all-zero NOP packet to decode.
  assign instr1_out = empty ? NOP_INSTR : w_head.instr1;
  assign instr2_out = empty ? NOP_INSTR : w_head.instr2;
  assign pca_out    = empty ? 32'h0     : w_head.pca;
  assign cia_out    = empty ? 32'h0     : w_head.cia;

endmodule

// File: tb/tb_ifid_queue.sv
// Self-checking bench for ifid_queue: directed vector table, reset/wrap
// sequences, and random traffic against a queue-based reference model.
module tb_ifid_queue;

  logic        CLK = 1'b0;
  logic        RESET = 1'b0;
  logic        flush = 1'b0, push_req = 1'b0, pop_req = 1'b0;
  logic [31:0] instr1_in = '0, instr2_in = '0, pca_in = '0, cia_in = '0;
  logic        full, almost_full, empty, overflow_err, underflow_err;
  logic [31:0] instr1_out, instr2_out, pca_out, cia_out;
  logic [2:0]  count;

  int n_checks = 0;
  int n_fail   = 0;

  ifid_queue dut (
    .CLK(CLK), .RESET(RESET), .flush(flush), .push_req(push_req),
    .instr1_in(instr1_in), .instr2_in(instr2_in), .pca_in(pca_in), .cia_in(cia_in),
    .full(full), .almost_full(almost_full), .pop_req(pop_req), .empty(empty),
    .instr1_out(instr1_out), .instr2_out(instr2_out), .pca_out(pca_out), .cia_out(cia_out),
    .count(count), .overflow_err(overflow_err), .underflow_err(underflow_err)
  );

  always #5 CLK = ~CLK;

  // Reference model: an ordered list of whole packets plus the two sticky flags.
  logic [127:0] mq[$];
  logic         m_ovf = 1'b0, m_unf = 1'b0;

  typedef struct {
    logic        f, pu, po;
    logic [31:0] i1;
    int          cnt;
    logic        ovf, unf;
    logic [31:0] h1;
  } vec_t;

  vec_t tbl[23];

  function automatic logic [127:0] pkt(input logic [31:0] i1);
    return {i1, ~i1, i1 + 32'h1000, i1 + 32'h2000};
  endfunction

  function automatic logic [127:0] head();
    return {instr1_out, instr2_out, pca_out, cia_out};
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drive one cycle of inputs, clock it, then settle past the edge.
  task automatic step(input logic f, input logic pu, input logic po, input logic [127:0] d);
    flush = f; push_req = pu; pop_req = po;
    {instr1_in, instr2_in, pca_in, cia_in} = d;
    @(posedge CLK);
    #1;
    flush = 0; push_req = 0; pop_req = 0;
  endtask

  // Model update from the queue rules: status sampled before the edge.
  task automatic model(input logic f, input logic pu, input logic po, input logic [127:0] d);
    bit was_full, was_empty;
    was_full  = (mq.size() == 4);
    was_empty = (mq.size() == 0);
    if (f) begin
      mq.delete(); m_ovf = 0; m_unf = 0;
    end else begin
      if (pu && was_full)  m_ovf = 1;
      if (po && was_empty) m_unf = 1;
      if (po && !was_empty) void'(mq.pop_front());
      if (pu && !was_full)  mq.push_back(d);
    end
  endtask

  task automatic cmp_model(input string tag);
    int n;
    n = mq.size();
    check({tag, ".count"},   128'(count), 128'(n));
    check({tag, ".empty"},   128'(empty), 128'(n == 0));
    check({tag, ".full"},    128'(full), 128'(n == 4));
    check({tag, ".afull"},   128'(almost_full), 128'(n >= 3));
    check({tag, ".ovf"},     128'(overflow_err), 128'(m_ovf));
    check({tag, ".unf"},     128'(underflow_err), 128'(m_unf));
    check({tag, ".head"},    head(), (n == 0) ? 128'h0 : mq[0]);
  endtask

  task automatic mstep(input string tag, input logic f, input logic pu, input logic po,
                       input logic [127:0] d);
    step(f, pu, po, d);
    model(f, pu, po, d);
    cmp_model(tag);
  endtask

  function automatic vec_t v(input logic f, input logic pu, input logic po, input logic [31:0] i1,
                             input int cnt, input logic ovf, input logic unf, input logic [31:0] h1);
    vec_t r;
    r.f = f; r.pu = pu; r.po = po; r.i1 = i1; r.cnt = cnt; r.ovf = ovf; r.unf = unf; r.h1 = h1;
    return r;
  endfunction

  initial begin
    //        f  pu po  instr1  cnt ovf unf head
    tbl[0]  = v(0, 1, 0, 32'h11, 1, 0, 0, 32'h11);
    tbl[1]  = v(0, 1, 0, 32'h22, 2, 0, 0, 32'h11);
    tbl[2]  = v(0, 1, 0, 32'h33, 3, 0, 0, 32'h11);
    tbl[3]  = v(0, 1, 0, 32'h44, 4, 0, 0, 32'h11);
    tbl[4]  = v(0, 0, 1, 32'h00, 3, 0, 0, 32'h22);
    tbl[5]  = v(0, 0, 1, 32'h00, 2, 0, 0, 32'h33);
    tbl[6]  = v(0, 0, 1, 32'h00, 1, 0, 0, 32'h44);
    tbl[7]  = v(0, 0, 1, 32'h00, 0, 0, 0, 32'h00);
    tbl[8]  = v(0, 1, 0, 32'h61, 1, 0, 0, 32'h61);
    tbl[9]  = v(0, 1, 0, 32'h62, 2, 0, 0, 32'h61);
    tbl[10] = v(0, 1, 0, 32'h63, 3, 0, 0, 32'h61);
    tbl[11] = v(0, 1, 0, 32'h64, 4, 0, 0, 32'h61);
    tbl[12] = v(0, 1, 1, 32'h55, 3, 1, 0, 32'h62);
    tbl[13] = v(0, 0, 1, 32'h00, 2, 1, 0, 32'h63);
    tbl[14] = v(0, 0, 1, 32'h00, 1, 1, 0, 32'h64);
    tbl[15] = v(0, 0, 1, 32'h00, 0, 1, 0, 32'h00);
    tbl[16] = v(0, 0, 1, 32'h00, 0, 1, 1, 32'h00);
    tbl[17] = v(0, 1, 0, 32'h71, 1, 1, 1, 32'h71);
    tbl[18] = v(0, 1, 0, 32'h72, 2, 1, 1, 32'h71);
    tbl[19] = v(0, 1, 0, 32'h73, 3, 1, 1, 32'h71);
    tbl[20] = v(1, 1, 1, 32'h74, 0, 0, 0, 32'h00);
    tbl[21] = v(0, 1, 0, 32'h81, 1, 0, 0, 32'h81);
    tbl[22] = v(0, 0, 1, 32'h00, 0, 0, 0, 32'h00);

    // Reset held low for two cycles.
    repeat (2) @(posedge CLK);
    #1;
    check("rst.count", 128'(count), 128'd0);
    check("rst.empty", 128'(empty), 128'd1);
    check("rst.full",  128'(full), 128'd0);
    check("rst.afull", 128'(almost_full), 128'd0);
    check("rst.errs",  128'({overflow_err, underflow_err}), 128'd0);
    check("rst.head",  head(), 128'h0);
    #2 RESET = 1'b1;

    foreach (tbl[i]) begin
      step(tbl[i].f, tbl[i].pu, tbl[i].po, pkt(tbl[i].i1));
      check($sformatf("vec%0d.count", i), 128'(count), 128'(tbl[i].cnt));
      check($sformatf("vec%0d.empty", i), 128'(empty), 128'(tbl[i].cnt == 0));
      check($sformatf("vec%0d.full", i),  128'(full), 128'(tbl[i].cnt == 4));
      check($sformatf("vec%0d.afull", i), 128'(almost_full), 128'(tbl[i].cnt >= 3));
      check($sformatf("vec%0d.ovf", i),   128'(overflow_err), 128'(tbl[i].ovf));
      check($sformatf("vec%0d.unf", i),   128'(underflow_err), 128'(tbl[i].unf));
      check($sformatf("vec%0d.head", i),  head(), (tbl[i].cnt == 0) ? 128'h0 : pkt(tbl[i].h1));
    end

    // Asynchronous reset mid-operation empties the queue before any edge.
    step(0, 1, 0, pkt(32'h91));
    step(0, 1, 0, pkt(32'h92));
    #2 RESET = 1'b0;
    #1;
    check("async_rst.count", 128'(count), 128'd0);
    check("async_rst.empty", 128'(empty), 128'd1);
    check("async_rst.head",  head(), 128'h0);
    @(posedge CLK);
    #2 RESET = 1'b1;
    mq.delete(); m_ovf = 0; m_unf = 0;
    mstep("post_rst", 0, 1, 0, pkt(32'h90));

    // Steady push+pop at count 2; pointers wrap several times.
    mstep("pp_fill", 0, 1, 0, pkt(32'hA0));
    for (int k = 0; k < 10; k++) begin
      mstep($sformatf("pp%0d", k), 0, 1, 1, pkt(32'hA1 + k));
      check($sformatf("pp%0d.cnt2", k), 128'(count), 128'd2);
    end

    // Random traffic against the model, flush occasionally.
    for (int k = 0; k < 400; k++) begin
      logic f, pu, po;
      logic [127:0] d;
      f  = ($urandom_range(0, 31) == 0);
      pu = ($urandom_range(0, 99) < 60);
      po = ($urandom_range(0, 99) < 45);
      d  = {$urandom, $urandom, $urandom, $urandom};
      mstep($sformatf("rnd%0d", k), f, pu, po, d);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ifid_queue.md
# ifid_queue

Decoupling FIFO between instruction fetch and decode. Each entry holds one fetch packet: two instruction words plus the PCA and CIA addresses. The fetch stage pushes a packet each cycle it asserts push_req, and the decode stage pops packets in order. The block exposes full and almost_full so fetch can stall, and flushes on a taken-branch redirect.

## Interface
- DEPTH, 4: number of entries; power of two, at least 2.
- AW, log2(DEPTH): pointer width. Derived; not overridden.

- CLK  in  1  clock, rising edge.
- RESET  in  1  asynchronous, active-low reset.
- flush  in  1  synchronous clear of all entries (branch redirect).
- push_req  in  1  fetch presents a packet this cycle.
- instr1_in  in  32  first instruction word.
- instr2_in  in  32  second instruction word.
- pca_in  in  32  PCA of the packet.
- cia_in  in  32  CIA of the packet.
- full  out  1  count == DEPTH.
- almost_full  out  1  count >= DEPTH-1.
- pop_req  in  1  decode consumes the head entry this cycle.
- empty  out  1  count == 0.
- instr1_out, instr2_out, pca_out, cia_out  out  32 each  head entry, first-word-fall-through.
- count  out  AW+1  current occupancy.
- overflow_err  out  1  sticky; set when a push arrives while full.
- underflow_err  out  1  sticky; set when a pop arrives while empty.

## Operation
- Storage: DEPTH x 128-bit array, with head pointer rd_ptr and tail pointer wr_ptr (AW bits each, natural wrap) and a count register of AW+1 bits.
- Push acceptance: push_ok = push_req && !full.
  - Full is evaluated before any same-cycle pop, so a push into a full queue is dropped even when a pop occurs that cycle.
  - An accepted push writes {instr1_in, instr2_in, pca_in, cia_in} at wr_ptr, then wr_ptr increments.
- Pop acceptance: pop_ok = pop_req && !empty. An accepted pop increments rd_ptr.
- Count update: count += push_ok - pop_ok. A simultaneous accepted push and pop leaves count unchanged.
- Outputs:
  - Head data = mem[rd_ptr] when !empty.
  - All four data outputs are forced to 0 when empty, so decode sees a NOP packet (instr 0x00000000).
- Flush has priority over push and pop in the same cycle:
  - rd_ptr, wr_ptr and count go to 0.
  - The concurrent push is discarded.
  - Memory contents are not cleared.
  - The error flags are cleared.
- Errors:
  - overflow_err is set on push_req && full.
  - underflow_err is set on pop_req && empty.
  - Both stay set until reset or flush. Neither error changes any pointer or count.
- No state machine beyond the pointers and count. The block is status-driven: empty, normal, full.

## Timing
- Reset (asynchronous, RESET low): rd_ptr = wr_ptr = 0, count = 0, empty = 1, full = 0, almost_full = 0, data outputs = 0, overflow_err = 0, underflow_err = 0. Memory is not reset.
- Push-to-visible latency is 1 cycle. A packet pushed at edge N is on the outputs after edge N, with empty low, provided the queue was empty.
- Pop takes effect at the edge. The next entry appears combinationally after that edge.
- full, almost_full, empty and count are registered-state derived. They change only on clock edges or on reset.
- Wrap-around: the pointers wrap from DEPTH-1 to 0 with no bubble.
- Reset asserted mid-operation: the queue empties immediately (asynchronously). After reset deasserts, the first push is accepted on the next edge.
- When almost_full is asserted, fetch must freeze. Fetch's registered push_req may still deliver one more packet, and DEPTH-1 headroom absorbs it.

## Structure
- Package ifid_pkg holds:
  - typedef ifid_entry_t as a packed struct {instr1, instr2, pca, cia}, 32 bits each.
  - constant IFID_DEPTH = 4.
  - constant NOP_INSTR = 32'h00000000.
- One sub-module, ifid_queue_mem: a DEPTH x ifid_entry_t storage array with synchronous write and asynchronous read. Pointer, count and flag logic stay in ifid_queue.

## Test plan
- Reset then idle: RESET low for 2 cycles -> empty = 1, count = 0, all outputs 0, both error flags 0.
- Fill and drain: push 4 packets with instr1 = 0x11, 0x22, 0x33, 0x44, no pops.
  - full = 1 after the 4th edge, and almost_full = 1 after the 3rd.
  - Then pop 4 times -> outputs show 0x11..0x44 in order, and empty = 1 at the end.
- Simultaneous push/pop at count = 2 for 10 cycles -> count stays 2, data stays ordered, and the pointers wrap past 3 -> 0 without loss.
- Push while full (instr1 = 0x55) together with a pop -> the push is dropped, count = 3, overflow_err = 1, and 0x55 is never output.
- Pop while empty -> underflow_err = 1, count stays 0, outputs stay 0.
- Flush with push_req = 1 at count = 3 -> the next cycle has empty = 1, count = 0, both errors 0, and the pushed packet is discarded.
